// File: rtl/decim_buf.sv
// Decimating show-ahead FIFO buffer: keeps one FIR sample in every DECIM valid
// samples and presents kept samples over valid/ready with a sticky overflow flag.
module decim_buf #(
  parameter int DECIM = 4,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [11:0]              d,
  output logic [11:0]              out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  input  logic                     clr_ovf
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int PW = (DECIM > 1) ? $clog2(DECIM) : 1;

  logic [11:0]   mem [DEPTH];
  logic [PW-1:0] phase_reg;
  logic [AW-1:0] rd_ptr_reg, wr_ptr_reg;
  logic [LW-1:0] level_reg, level_next;
  logic [11:0]   out_data_reg, head_next;
  logic          out_valid_reg;
  logic          overflow_reg;

  logic          kept, full, pop, push;
  logic [AW-1:0] rd_ptr_inc;

  assign kept       = in_valid && (phase_reg == '0);
  assign full       = (level_reg == LW'(DEPTH));
  assign pop        = out_valid_reg && out_ready;
  assign push       = kept && (!full || pop);
  assign rd_ptr_inc = rd_ptr_reg + AW'(1);

  always_comb begin
    level_next = level_reg;
    case ({push, pop})
      2'b10:   level_next = level_reg + LW'(1);
      2'b01:   level_next = level_reg - LW'(1);
      default: level_next = level_reg;
    endcase
  end

  // Head register: the next entry after a pop, or the incoming sample when it
  // lands in an otherwise-empty FIFO; an emptied FIFO keeps the last popped value.
  always_comb begin
    head_next = out_data_reg;
    if (pop && (level_reg > LW'(1)))
      head_next = mem[rd_ptr_inc];
    else if (push && ((level_reg == '0) || (pop && (level_reg == LW'(1)))))
      head_next = d;
  end

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr_reg] <= d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_reg     <= '0;
      rd_ptr_reg    <= '0;
      wr_ptr_reg    <= '0;
      level_reg     <= '0;
      out_data_reg  <= '0;
      out_valid_reg <= 1'b0;
      overflow_reg  <= 1'b0;
    end else begin
      if (in_valid) begin
        if (phase_reg == PW'(DECIM - 1))
          phase_reg <= '0;
        else
          phase_reg <= phase_reg + PW'(1);
      end
      if (push)
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop)
        rd_ptr_reg <= rd_ptr_inc;
      level_reg     <= level_next;
      out_valid_reg <= (level_next != '0);
      out_data_reg  <= head_next;
      // A drop in the same cycle as a clear leaves the flag set.
      if (kept && full && !pop)
        overflow_reg <= 1'b1;
      else if (clr_ovf)
        overflow_reg <= 1'b0;
    end
  end

  assign out_data  = out_data_reg;
  assign out_valid = out_valid_reg;
  assign level     = level_reg;
  assign overflow  = overflow_reg;

endmodule

// File: tb/tb_decim_buf.sv
// Directed testbench for decim_buf: one DECIM=4 instance and one DECIM=1 instance
// share clock and reset; each scenario task checks its own results inline.
module tb_decim_buf;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Instance A: DECIM=4, DEPTH=8
  logic        a_in_valid = 1'b0, a_out_ready = 1'b0, a_clr = 1'b0;
  logic [11:0] a_d = '0;
  logic [11:0] a_out_data;
  logic        a_out_valid, a_overflow;
  logic [3:0]  a_level;

  // Instance B: DECIM=1, DEPTH=8
  logic        b_in_valid = 1'b0, b_out_ready = 1'b0, b_clr = 1'b0;
  logic [11:0] b_d = '0;
  logic [11:0] b_out_data;
  logic        b_out_valid, b_overflow;
  logic [3:0]  b_level;

  decim_buf #(.DECIM(4), .DEPTH(8)) u_a (
    .clk(clk), .rst(rst), .in_valid(a_in_valid), .d(a_d),
    .out_data(a_out_data), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .level(a_level), .overflow(a_overflow), .clr_ovf(a_clr)
  );

  decim_buf #(.DECIM(1), .DEPTH(8)) u_b (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .d(b_d),
    .out_data(b_out_data), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .level(b_level), .overflow(b_overflow), .clr_ovf(b_clr)
  );

  // Advance one edge, noting whether a pop happens on it and the popped value.
  task automatic cycle_a(output logic popped, output logic [11:0] val);
    popped = a_out_valid && a_out_ready;
    val    = a_out_data;
    @(posedge clk); #1;
  endtask

  task automatic cycle_b(output logic popped, output logic [11:0] val);
    popped = b_out_valid && b_out_ready;
    val    = b_out_data;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({a_out_valid, a_level, a_overflow, a_out_data} !== 18'd0) begin
      n_fail++;
      $display("FAIL reset_a: valid=%0b level=%0d ovf=%0b data=%0d, required all 0",
               a_out_valid, a_level, a_overflow, a_out_data);
    end
    n_checks++;
    if ({b_out_valid, b_level, b_overflow, b_out_data} !== 18'd0) begin
      n_fail++;
      $display("FAIL reset_b: valid=%0b level=%0d ovf=%0b data=%0d, required all 0",
               b_out_valid, b_level, b_overflow, b_out_data);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    $display("test_reset done");
  endtask

  task automatic test_decimation;
    int          exp_v[4] = '{1, 5, 9, 13};
    int          got[$];
    logic        p;
    logic [11:0] v;
    a_out_ready = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      a_in_valid = 1'b1;
      a_d = 12'(i);
      cycle_a(p, v);
      if (p) got.push_back(int'(v));
      if (i == 1) begin
        n_checks++;
        if (a_out_valid !== 1'b1 || a_out_data !== 12'd1) begin
          n_fail++;
          $display("FAIL decim_latency: valid=%0b data=%0d, required valid=1 data=1",
                   a_out_valid, a_out_data);
        end
      end
    end
    a_in_valid = 1'b0;
    repeat (4) begin
      cycle_a(p, v);
      if (p) got.push_back(int'(v));
    end
    n_checks++;
    if (got.size() != 4) begin
      n_fail++;
      $display("FAIL decim_count: got %0d outputs, required 4", got.size());
    end
    for (int k = 0; k < 4 && k < got.size(); k++) begin
      n_checks++;
      if (got[k] != exp_v[k]) begin
        n_fail++;
        $display("FAIL decim_data[%0d]: got %0d, required %0d", k, got[k], exp_v[k]);
      end
    end
    n_checks++;
    if (a_overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL decim_ovf: overflow=%0b, required 0", a_overflow);
    end
    $display("test_decimation done, %0d outputs", got.size());
  endtask

  task automatic test_gapped;
    int          exp_v[2] = '{1, 5};
    int          got[$];
    int          s = 1;
    logic        p;
    logic [11:0] v;
    a_out_ready = 1'b1;
    for (int c = 0; c < 16; c++) begin
      a_in_valid = (c % 2 == 0);
      a_d = a_in_valid ? 12'(s) : 12'hABC;
      if (a_in_valid) s++;
      cycle_a(p, v);
      if (p) got.push_back(int'(v));
    end
    a_in_valid = 1'b0;
    repeat (3) begin
      cycle_a(p, v);
      if (p) got.push_back(int'(v));
    end
    n_checks++;
    if (got.size() != 2) begin
      n_fail++;
      $display("FAIL gapped_count: got %0d outputs, required 2", got.size());
    end
    for (int k = 0; k < 2 && k < got.size(); k++) begin
      n_checks++;
      if (got[k] != exp_v[k]) begin
        n_fail++;
        $display("FAIL gapped_data[%0d]: got %0d, required %0d", k, got[k], exp_v[k]);
      end
    end
    $display("test_gapped done, %0d outputs", got.size());
  endtask

  task automatic test_overflow;
    int          got[$];
    logic        p;
    logic [11:0] v;
    b_out_ready = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      b_in_valid = 1'b1;
      b_d = 12'(i);
      cycle_b(p, v);
      if (i == 8) begin
        n_checks++;
        if (b_level !== 4'd8 || b_overflow !== 1'b0) begin
          n_fail++;
          $display("FAIL ovf_full: level=%0d ovf=%0b, required level=8 ovf=0", b_level, b_overflow);
        end
      end
      if (i == 9) begin
        n_checks++;
        if (b_level !== 4'd8 || b_overflow !== 1'b1) begin
          n_fail++;
          $display("FAIL ovf_set: level=%0d ovf=%0b, required level=8 ovf=1", b_level, b_overflow);
        end
      end
    end
    b_in_valid = 1'b0;
    b_out_ready = 1'b1;
    repeat (9) begin
      cycle_b(p, v);
      if (p) got.push_back(int'(v));
    end
    n_checks++;
    if (got.size() != 8) begin
      n_fail++;
      $display("FAIL ovf_drain_count: got %0d outputs, required 8", got.size());
    end
    for (int k = 0; k < 8 && k < got.size(); k++) begin
      n_checks++;
      if (got[k] != k + 1) begin
        n_fail++;
        $display("FAIL ovf_drain[%0d]: got %0d, required %0d", k, got[k], k + 1);
      end
    end
    n_checks++;
    if (b_out_valid !== 1'b0 || b_level !== 4'd0 || b_overflow !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_sticky: valid=%0b level=%0d ovf=%0b, required 0 0 1",
               b_out_valid, b_level, b_overflow);
    end
    b_out_ready = 1'b0;
    b_clr = 1'b1;
    cycle_b(p, v);
    b_clr = 1'b0;
    n_checks++;
    if (b_overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_clear: overflow=%0b, required 0", b_overflow);
    end
    $display("test_overflow done, %0d outputs", got.size());
  endtask

  task automatic test_full_pop;
    int          got[$];
    logic        p;
    logic [11:0] v;
    b_out_ready = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      b_in_valid = 1'b1;
      b_d = 12'(i);
      cycle_b(p, v);
    end
    b_d = 12'd9;
    b_out_ready = 1'b1;
    cycle_b(p, v);
    if (p) got.push_back(int'(v));
    n_checks++;
    if (b_level !== 4'd8 || b_overflow !== 1'b0 || b_out_data !== 12'd2) begin
      n_fail++;
      $display("FAIL fullpop_state: level=%0d ovf=%0b data=%0d, required 8 0 2",
               b_level, b_overflow, b_out_data);
    end
    b_in_valid = 1'b0;
    repeat (9) begin
      cycle_b(p, v);
      if (p) got.push_back(int'(v));
    end
    n_checks++;
    if (got.size() != 9) begin
      n_fail++;
      $display("FAIL fullpop_count: got %0d pops, required 9", got.size());
    end
    for (int k = 1; k < 9 && k < got.size(); k++) begin
      n_checks++;
      if (got[k] != k + 1) begin
        n_fail++;
        $display("FAIL fullpop_drain[%0d]: got %0d, required %0d", k, got[k], k + 1);
      end
    end
    $display("test_full_pop done, %0d pops", got.size());
  endtask

  task automatic test_extremes;
    logic        p;
    logic [11:0] v;
    b_out_ready = 1'b0;
    b_in_valid = 1'b1;
    b_d = 12'h800;
    cycle_b(p, v);
    n_checks++;
    if (b_out_valid !== 1'b1 || b_out_data !== 12'h800) begin
      n_fail++;
      $display("FAIL extreme_neg: valid=%0b data=%0d, required valid=1 data=-2048",
               b_out_valid, $signed(b_out_data));
    end
    b_d = 12'h7FF;
    b_out_ready = 1'b1;
    cycle_b(p, v);
    n_checks++;
    if (b_out_valid !== 1'b1 || b_out_data !== 12'h7FF || b_level !== 4'd1) begin
      n_fail++;
      $display("FAIL extreme_pos: valid=%0b data=%0d level=%0d, required 1 2047 1",
               b_out_valid, $signed(b_out_data), b_level);
    end
    b_in_valid = 1'b0;
    cycle_b(p, v);
    n_checks++;
    if (b_out_valid !== 1'b0 || b_out_data !== 12'h7FF) begin
      n_fail++;
      $display("FAIL extreme_hold: valid=%0b data=%0d, required valid=0 data=2047",
               b_out_valid, $signed(b_out_data));
    end
    b_out_ready = 1'b0;
    $display("test_extremes done");
  endtask

  task automatic test_async_reset;
    logic        p;
    logic [11:0] v;
    a_out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      a_in_valid = 1'b1;
      a_d = 12'(40 + i);
      cycle_a(p, v);
    end
    a_in_valid = 1'b0;
    b_out_ready = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      b_in_valid = 1'b1;
      b_d = 12'(20 + i);
      cycle_b(p, v);
    end
    b_in_valid = 1'b0;
    b_out_ready = 1'b1;
    repeat (3) cycle_b(p, v);
    b_out_ready = 1'b0;
    n_checks++;
    if (b_level !== 4'd5 || b_overflow !== 1'b1) begin
      n_fail++;
      $display("FAIL arst_pre: level=%0d ovf=%0b, required level=5 ovf=1", b_level, b_overflow);
    end
    #3;
    rst = 1'b1;
    #1;
    n_checks++;
    if ({b_out_valid, b_level, b_overflow, b_out_data} !== 18'd0) begin
      n_fail++;
      $display("FAIL arst_immediate: valid=%0b level=%0d ovf=%0b data=%0d, required all 0",
               b_out_valid, b_level, b_overflow, b_out_data);
    end
    #2;
    rst = 1'b0;
    a_in_valid = 1'b1;
    a_d = 12'd77;
    b_in_valid = 1'b1;
    b_d = 12'hFFB;
    @(posedge clk); #1;
    a_in_valid = 1'b0;
    b_in_valid = 1'b0;
    n_checks++;
    if (a_out_valid !== 1'b1 || a_out_data !== 12'd77 || a_level !== 4'd1) begin
      n_fail++;
      $display("FAIL arst_first_kept_a: valid=%0b data=%0d level=%0d, required 1 77 1",
               a_out_valid, a_out_data, a_level);
    end
    n_checks++;
    if (b_out_valid !== 1'b1 || b_out_data !== 12'hFFB || b_level !== 4'd1) begin
      n_fail++;
      $display("FAIL arst_first_kept_b: valid=%0b data=%0d level=%0d, required 1 -5 1",
               b_out_valid, $signed(b_out_data), b_level);
    end
    $display("test_async_reset done");
  endtask

  initial begin
    test_reset();
    test_decimation();
    test_gapped();
    test_overflow();
    test_full_pop();
    test_extremes();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
